// File: rtl/ser_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser_arb_pkg
// Purpose  : Shared types and constants for the serializer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ser_arb_pkg;

    // Sequencer states; the encoding is fixed so it can be probed externally
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    // Inter-word gap counter width (GAP is limited to 0..15)
    localparam int c_gap_cw = 4;

    // Busy-timeout counter width (TIMEOUT is limited to 1..256)
    localparam int c_to_cw = 8;

endpackage
`default_nettype wire

// File: rtl/ser_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ser_arbiter_if
// Purpose  : Requester handshake and serializer-side bundle of ser_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ser_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    logic [N-1:0]         i_req_valid;
    logic [N*WIDTH-1:0]   i_req_data;
    logic [N-1:0]         o_req_ready;
    logic                 o_ser_wen;
    logic [WIDTH-1:0]     o_ser_data;
    logic                 i_ser_busy;
    logic [$clog2(N)-1:0] o_grant_id;
    logic                 o_active;
    logic                 o_err;

    // Arbiter side
    modport master (
        input  i_req_valid, i_req_data, i_ser_busy,
        output o_req_ready, o_ser_wen, o_ser_data, o_grant_id, o_active, o_err
    );

    // Environment side (requesters + serializer)
    modport slave (
        output i_req_valid, i_req_data, i_ser_busy,
        input  o_req_ready, o_ser_wen, o_ser_data, o_grant_id, o_active, o_err
    );
endinterface
`default_nettype wire

// File: rtl/ser_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: first set request searching
//            upward from last+1, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_k;
    logic          w_found;

    // Scan N candidates starting after the previous winner; keep the first hit
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 1; i <= N; i++) begin
            w_k = IW'((int'(i_last) + i) % N);
            if (!w_found && i_req[w_k]) begin
                w_found    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/ser_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ser_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one serializer among N
//            word-wide requesters (grant, load, track busy, optional gap).
// Revision : 1.0 - initial release
// ============================================================================
module ser_arbiter
    import ser_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ser_arbiter_if.master bus
);
    localparam int c_iw = $clog2(N);

    state_t            r_state;
    state_t            w_next;
    logic [c_iw-1:0]   r_last;
    logic [c_iw-1:0]   r_grant_id;
    logic [WIDTH-1:0]  r_ser_data;
    logic              r_ser_wen;
    logic              r_err;
    logic [c_gap_cw-1:0] r_gap_cnt;
    logic [c_to_cw-1:0]  r_to_cnt;

    logic [N-1:0]      w_gnt;
    logic [c_iw-1:0]   w_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_timeout;

    rr_pick #(.N(N), .IW(c_iw)) u_pick (
        .i_req  (bus.i_req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Next-state logic; accept only from IDLE with the serializer free
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !bus.i_ser_busy && !i_rst) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD:      w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.i_ser_busy) begin
                    w_next = ST_SHIFT;
                end else if (r_to_cnt == c_to_cw'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bus.i_ser_busy) begin
                    w_next = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_cw'(GAP - 1)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture registers, strobes and the gap/timeout counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last     <= c_iw'(N - 1);
            r_grant_id <= '0;
            r_ser_data <= '0;
            r_ser_wen  <= 1'b0;
            r_err      <= 1'b0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_ser_wen <= w_accept;
            r_err     <= w_timeout;
            if (w_accept) begin
                r_ser_data <= bus.i_req_data[w_idx*WIDTH +: WIDTH];
                r_grant_id <= w_idx;
                r_last     <= w_idx;
            end
            // LOAD always precedes WAIT_BUSY, so clearing here clears on entry
            if (r_state == ST_LOAD) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY) begin
                r_to_cnt <= r_to_cnt + c_to_cw'(1);
            end
            if (r_state == ST_SHIFT) begin
                r_gap_cnt <= '0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + c_gap_cw'(1);
            end
        end
    end

    assign bus.o_req_ready = w_accept ? w_gnt : '0;
    assign bus.o_ser_wen   = r_ser_wen;
    assign bus.o_ser_data  = r_ser_data;
    assign bus.o_grant_id  = r_grant_id;
    assign bus.o_active    = (r_state != ST_IDLE);
    assign bus.o_err       = r_err;

endmodule
`default_nettype wire

// File: doc/ser_arbiter.md
# ser_arbiter

Round-robin arbiter and sequencer that shares one `serializer` instance among N word-wide requesters. Each requester offers a word with a valid/ready handshake. The arbiter grants one requester, loads its word into the serializer with a single-cycle write-enable, then tracks the serializer's busy flag until the word has fully shifted out. It sits between the packet-producing logic and the serializer, so upstream blocks never drive `i_wen` on the serializer directly.

## Interface

Parameters:
- `WIDTH`, default 8: word width; must match the serializer `WIDTH`.
- `N`, default 4: number of requesters, N ≥ 2.
- `GAP`, default 1: idle cycles inserted after each word, 0..15.
- `TIMEOUT`, default 4: maximum cycles to wait for the serializer busy flag to rise, ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  system clock, rising edge
- `i_rst`  in  1  synchronous active-high reset
- `i_req_valid`  in  N  requester k has a word pending
- `i_req_data`  in  N*WIDTH  word of requester k at bits [k*WIDTH +: WIDTH]
- `o_req_ready`  out  N  one-hot accept strobe; a transfer occurs when valid and ready are both high
- `o_ser_wen`  out  1  to serializer `i_wen`
- `o_ser_data`  out  WIDTH  to serializer `i_data`
- `i_ser_busy`  in  1  from serializer `o_busy`
- `o_grant_id`  out  $clog2(N)  index of the requester currently owning the serializer
- `o_active`  out  1  high in every state except IDLE
- `o_err`  out  1  one-cycle pulse when a busy timeout occurs

## Operation

- States: IDLE, LOAD, WAIT_BUSY, SHIFT, GAP.
- **IDLE**
  - If any `i_req_valid` is high and `i_ser_busy` is low, pick g = the first valid requester searching from `last+1` modulo N.
  - Assert `o_req_ready[g]` combinationally in that cycle.
  - Capture the word into `o_ser_data` and g into `o_grant_id`, set `last` to g, and go to LOAD.
- **LOAD**
  - `o_ser_wen` is high for exactly this one cycle (registered).
  - Next state is WAIT_BUSY.
- **WAIT_BUSY**
  - If `i_ser_busy` is high, go to SHIFT.
  - If `i_ser_busy` has not been high after TIMEOUT cycles in this state, pulse `o_err` for one cycle, drop the word and go to IDLE. `last` stays advanced.
- **SHIFT**
  - Remain while `i_ser_busy` is high.
  - On the first cycle `i_ser_busy` is sampled low, go to GAP if GAP > 0, otherwise to IDLE.
- **GAP**: count GAP cycles, then go to IDLE.
- Requesters hold valid and data stable until ready. The arbiter never asserts ready outside IDLE.
- `o_ser_data` and `o_grant_id` hold their value from capture until the next capture.

## Timing

- Reset values:
  - state = IDLE.
  - `o_req_ready`, `o_ser_wen`, `o_ser_data`, `o_grant_id`, `o_active` and `o_err` are all 0.
  - `last` = N-1, so requester 0 has first priority.
  - The GAP and timeout counters are 0.
- Latency: accept in cycle t → `o_ser_wen` high in cycle t+1.
- Next accept is no earlier than GAP+1 cycles after the first cycle in which SHIFT samples `i_ser_busy` low.
- With a serializer whose busy flag rises one cycle after `i_wen` and stays high for WIDTH cycles, and WIDTH=8, GAP=1:
  - accept at cycle 0;
  - `o_ser_wen` at cycle 1;
  - busy high during cycles 2–9;
  - next accept at cycle 12.
- Single requester: words are issued back-to-back at the period above, with no starvation delay.
- If `i_ser_busy` is high while in IDLE (a foreign load), no grant is issued until it falls.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at their reset values.
  - The captured word is discarded; no `o_ser_wen` is issued.
- The timeout counter clears on entry to WAIT_BUSY. `o_err` never coincides with `o_ser_wen`.

## Structure

- Package `ser_arb_pkg` holds:
  - the state enumeration (3-bit encoding: IDLE=0, LOAD=1, WAIT_BUSY=2, SHIFT=3, GAP=4);
  - the GAP counter width constant (4 bits);
  - the TIMEOUT counter width constant.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: N-bit request vector and `last`.
  - Outputs: one-hot grant, grant index, and an `any` flag.
  - Reusable by other shared-resource arbiters.
- `ser_arbiter` itself contains the FSM, the data/ID capture registers and the two counters.

## Test plan

- Reset, then `i_req_valid`=4'b0001 with data 8'h18 → `o_req_ready`=4'b0001 at cycle 0, `o_ser_wen` at cycle 1, and the deserializer returns 8'h18 with `o_valid`.
- All four requesters valid with data 8'hA0..8'hA3 held → grant order 0, 1, 2, 3, 0, with accepts 12 cycles apart (WIDTH=8, GAP=1).
- Requesters 1 and 3 valid, `last`=1 → grant 3, then 1; no grant is given to the idle requesters 0 or 2.
- Tie `i_ser_busy` low after a load → `o_err` pulses exactly TIMEOUT cycles after entering WAIT_BUSY, state returns to IDLE, and the next grant goes to requester `last+1`.
- Assert `i_rst` in the third SHIFT cycle → all outputs are 0 the next cycle; after release, requester 0 wins first.
- Hold `i_ser_busy` high externally with requests pending → no `o_req_ready` until busy falls, then a grant in the first cycle it is low.
